// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: instruction register plus FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   instr_in, fetch_ack        instruction word and its valid handshake
//   mem_ack                    data RAM access complete
//   branch_check               ALU compare result, used in BRANCH execute only
//   fetch_req                  instruction request at current PC
//   alu_code                   ALU operation select (EXECUTE only)
//   ram_read, ram_write        data RAM strobes, ram_adr their address
//   reg_read, reg_write        regfile enables, reg1/reg2 register selects
//   pc_inc, pc_jump, pc_branch PC update pulses
//   halted, fault              sticky status: HALT executed / handshake timeout
module multicycle_control_unit #(
    parameter int REG_ADDR_W  = 2,
    parameter int MEM_ADDR_W  = 8,
    parameter int INSTR_W     = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INSTR_W-1:0]    instr_in,
    input  logic                  fetch_ack,
    input  logic                  mem_ack,
    input  logic                  branch_check,
    output logic                  fetch_req,
    output logic [3:0]            alu_code,
    output logic                  ram_read,
    output logic                  ram_write,
    output logic [MEM_ADDR_W-1:0] ram_adr,
    output logic                  reg_read,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] reg1,
    output logic [REG_ADDR_W-1:0] reg2,
    output logic                  pc_inc,
    output logic                  pc_jump,
    output logic                  pc_branch,
    output logic                  halted,
    output logic                  fault
);
    if (INSTR_W != 4 + 2 * REG_ADDR_W + MEM_ADDR_W) begin : g_bad_width
        $error("INSTR_W must equal 4 + 2*REG_ADDR_W + MEM_ADDR_W");
    end
    typedef enum logic [2:0] {RST, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, FAULT} state_t;
    state_t state;
    logic [INSTR_W-1:0] ir;
    logic [7:0] wait_cnt;
    logic [3:0] op;
    logic is_alu, is_mem, timed_out, active;
    assign op        = ir[INSTR_W-1 -: 4];
    assign is_alu    = op >= 4'h1 && op <= 4'h9;
    assign is_mem    = op == 4'hA || op == 4'hB;
    // limit reached on this cycle's miss; an ack in the same cycle still wins
    assign timed_out = wait_cnt == 8'(MEM_TIMEOUT - 1);
    assign active    = state inside {DECODE, EXECUTE, MEM, WRITEBACK};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RST;
            ir       <= '0;
            wait_cnt <= '0;
        end else begin
            // counter only survives while a wait state stays unacked
            wait_cnt <= '0;
            case (state)
                RST:       state <= FETCH;
                FETCH:     if (fetch_ack) begin
                               ir    <= instr_in;
                               state <= DECODE;
                           end else if (timed_out) state <= FAULT;
                           else wait_cnt <= wait_cnt + 8'd1;
                DECODE:    state <= EXECUTE;
                EXECUTE:   state <= is_alu ? WRITEBACK : is_mem ? MEM : op == 4'hF ? HALT : FETCH;
                MEM:       if (mem_ack) state <= op == 4'hA ? WRITEBACK : FETCH;
                           else if (timed_out) state <= FAULT;
                           else wait_cnt <= wait_cnt + 8'd1;
                WRITEBACK: state <= FETCH;
                default:   state <= state;
            endcase
        end
    end
    always_comb begin
        fetch_req = state == FETCH;
        reg_read  = state == DECODE;
        pc_inc    = state == DECODE;
        alu_code  = state != EXECUTE ? 4'h0 : is_alu ? op : op == 4'hD ? 4'h2 : 4'h0;
        ram_read  = state == MEM && op == 4'hA;
        ram_write = state == MEM && op == 4'hB;
        ram_adr   = active ? ir[MEM_ADDR_W-1:0] : '0;
        reg1      = active ? ir[INSTR_W-5 -: REG_ADDR_W] : '0;
        reg2      = active ? ir[MEM_ADDR_W +: REG_ADDR_W] : '0;
        reg_write = state == WRITEBACK;
        pc_jump   = state == EXECUTE && op == 4'hC;
        pc_branch = state == EXECUTE && op == 4'hD && branch_check;
        halted    = state == HALT;
        fault     = state == FAULT;
    end
endmodule
